// File: rtl/rkey_bank.sv
// rkey_bank: round-key store; loads expanded AES round keys, replays them forward or reverse.
// Latency: in_ready one cycle after load_start; out_valid one cycle after rd_start; one key per cycle.
// Backpressure: in_ready low outside LOAD; replay holds out_rk/out_idx/out_last while out_ready is low.
module rkey_bank #(
   parameter int KEY_W  = 128,
   parameter int MAX_RK = 15,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       in_nk,
   input  logic             load_start,
   input  logic             in_valid,
   input  logic [KEY_W-1:0] in_rk,
   output logic             in_ready,
   output logic             load_done,
   output logic             cfg_err,
   input  logic             rd_start,
   input  logic             rd_inv,
   output logic             out_valid,
   output logic [KEY_W-1:0] out_rk,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   input  logic             out_ready
);

   typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_FULL, S_READ} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_nrk;
   logic [IDX_W-1:0] r_wr_cnt;
   logic [IDX_W-1:0] r_rd_ptr;
   logic             r_inv;
   logic             r_cfg_err;
   logic [KEY_W-1:0] r_bank [MAX_RK];

   int               w_nrk_req;
   logic             w_cfg_ok;
   logic [IDX_W-1:0] w_nrk_m1;
   logic             w_wr_en;
   logic             w_last;
   logic             w_rd_go;

   // Decode requested key count and derive shared control terms
   always_comb begin
      w_nrk_req = 15;
      case (in_nk)
         2'd0:    w_nrk_req = 11;
         2'd1:    w_nrk_req = 13;
         default: w_nrk_req = 15;
      endcase
      w_cfg_ok = (w_nrk_req <= MAX_RK);
      w_nrk_m1 = r_nrk - IDX_W'(1);
      // load_start steals the cycle: a coincident beat is dropped
      w_wr_en  = (r_state == S_LOAD) && in_valid && !load_start;
      w_rd_go  = (r_state == S_FULL) && rd_start && !load_start;
      w_last   = (r_state == S_READ) && (r_rd_ptr == (r_inv ? '0 : w_nrk_m1));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; load_start overrides everything else
   always_comb begin
      w_state_nxt = r_state;
      if (load_start) begin
         w_state_nxt = w_cfg_ok ? S_LOAD : S_EMPTY;
      end else begin
         case (r_state)
            S_LOAD:  if (in_valid && (r_wr_cnt == w_nrk_m1)) w_state_nxt = S_FULL;
            S_FULL:  if (rd_start) w_state_nxt = S_READ;
            S_READ:  if (out_ready && w_last) w_state_nxt = S_FULL;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // Output decode from registered state (in_ready also sees load_start)
   always_comb begin
      in_ready  = (r_state == S_LOAD) && !load_start;
      load_done = (r_state == S_FULL) || (r_state == S_READ);
      out_valid = (r_state == S_READ);
      out_rk    = '0;
      out_idx   = '0;
      if (r_state == S_READ) begin
         out_rk  = r_bank[r_rd_ptr];
         out_idx = r_rd_ptr;
      end
      out_last  = w_last;
   end

   assign cfg_err = r_cfg_err;

   // Control counters, pointers and the one-cycle config error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nrk     <= '0;
         r_wr_cnt  <= '0;
         r_rd_ptr  <= '0;
         r_inv     <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= load_start && !w_cfg_ok;
         if (load_start) begin
            if (w_cfg_ok) begin
               r_nrk <= IDX_W'(w_nrk_req);
            end
            r_wr_cnt <= '0;
         end else if (w_wr_en) begin
            r_wr_cnt <= r_wr_cnt + IDX_W'(1);
         end
         if (w_rd_go) begin
            r_inv    <= rd_inv;
            r_rd_ptr <= rd_inv ? w_nrk_m1 : '0;
         end else if ((r_state == S_READ) && out_ready && !w_last) begin
            r_rd_ptr <= r_inv ? (r_rd_ptr - IDX_W'(1)) : (r_rd_ptr + IDX_W'(1));
         end
      end
   end

   // Key storage: plain registers, no reset; validity is tracked by the FSM
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_bank[r_wr_cnt] <= in_rk;
      end
   end

endmodule

// File: tb/tb_rkey_bank.sv
// tb_rkey_bank: table-driven per-cycle vectors for rkey_bank plus hand-written corner sequences.
module tb_rkey_bank;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   typedef struct packed {
      logic         ls;
      logic [1:0]   nk;
      logic         iv;
      logic [127:0] rk;
      logic         rs;
      logic         ri;
      logic         ordy;
   } in_t;

   typedef struct packed {
      logic         irdy;
      logic         ld;
      logic         cerr;
      logic         ov;
      logic [127:0] ork;
      logic [3:0]   oidx;
      logic         olast;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t e;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // main instance (MAX_RK = 15)
   in_t          cur;
   out_t         got;
   logic         load_start, in_valid, in_ready, load_done, cfg_err;
   logic [1:0]   in_nk;
   logic [127:0] in_rk, out_rk;
   logic         rd_start, rd_inv, out_valid, out_last, out_ready;
   logic [3:0]   out_idx;

   assign {load_start, in_nk, in_valid, in_rk, rd_start, rd_inv, out_ready} = cur;
   assign got = {in_ready, load_done, cfg_err, out_valid, out_rk, out_idx, out_last};

   rkey_bank #(.KEY_W(128), .MAX_RK(15), .IDX_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_nk(in_nk), .load_start(load_start),
      .in_valid(in_valid), .in_rk(in_rk), .in_ready(in_ready),
      .load_done(load_done), .cfg_err(cfg_err), .rd_start(rd_start),
      .rd_inv(rd_inv), .out_valid(out_valid), .out_rk(out_rk),
      .out_idx(out_idx), .out_last(out_last), .out_ready(out_ready)
   );

   // reduced-depth instance (MAX_RK = 13) for config errors
   in_t          b_cur;
   out_t         b_got;
   logic         b_load_start, b_in_valid, b_in_ready, b_load_done, b_cfg_err;
   logic [1:0]   b_in_nk;
   logic [127:0] b_in_rk, b_out_rk;
   logic         b_rd_start, b_rd_inv, b_out_valid, b_out_last, b_out_ready;
   logic [3:0]   b_out_idx;

   assign {b_load_start, b_in_nk, b_in_valid, b_in_rk, b_rd_start, b_rd_inv, b_out_ready} = b_cur;
   assign b_got = {b_in_ready, b_load_done, b_cfg_err, b_out_valid, b_out_rk, b_out_idx, b_out_last};

   rkey_bank #(.KEY_W(128), .MAX_RK(13), .IDX_W(4)) dut13 (
      .clk(clk), .rst_n(rst_n), .in_nk(b_in_nk), .load_start(b_load_start),
      .in_valid(b_in_valid), .in_rk(b_in_rk), .in_ready(b_in_ready),
      .load_done(b_load_done), .cfg_err(b_cfg_err), .rd_start(b_rd_start),
      .rd_inv(b_rd_inv), .out_valid(b_out_valid), .out_rk(b_out_rk),
      .out_idx(b_out_idx), .out_last(b_out_last), .out_ready(b_out_ready)
   );

   vec_t vecs[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   function automatic logic [127:0] key(input int b);
      logic [7:0] v;
      v = b[7:0];
      return {16{v}};
   endfunction

   function automatic in_t mk_i(input logic ls, input logic [1:0] nk, input logic iv,
                                input logic [127:0] rk, input logic rs, input logic ri,
                                input logic ordy);
      return {ls, nk, iv, rk, rs, ri, ordy};
   endfunction

   function automatic out_t mk_o(input logic irdy, input logic ld, input logic cerr,
                                 input logic ov, input logic [127:0] rk,
                                 input logic [3:0] idx, input logic last);
      return {irdy, ld, cerr, ov, rk, idx, last};
   endfunction

   function automatic in_t beat(input int k);
      return mk_i(L, 2'd0, H, key(k), L, L, L);
   endfunction

   // replay row: key k at round index idx
   function automatic out_t ord(input int k, input int idx, input logic last);
      return mk_o(L, H, L, H, key(k), 4'(idx), last);
   endfunction

   task automatic add(input in_t i, input out_t e);
      vec_t v;
      v.i = i;
      v.e = e;
      vecs.push_back(v);
   endtask

   task automatic chk(input int id, input out_t g, input out_t e);
      n_tot++;
      if (g === e) n_pass++;
      else $display("FAIL check %0d: got %h required %h", id, g, e);
   endtask

   in_t  idle, idle_r;
   out_t o_zero, o_full, o_load;

   initial begin
      int b, c;
      cur    = '0;
      b_cur  = '0;
      rst_n  = 1'b0;
      idle   = '0;
      idle_r = mk_i(L, 2'd0, L, '0, L, L, H);
      o_zero = '0;
      o_full = mk_o(L, H, L, L, '0, 4'd0, L);
      o_load = mk_o(H, L, L, L, '0, 4'd0, L);

      // --- EMPTY behaviour: idle, rd_start ignored
      add(idle, o_zero);
      add(mk_i(L, 2'd0, L, '0, H, L, H), o_zero);
      add(idle_r, o_zero);
      // --- AES-128 load, K_i = i replicated
      add(mk_i(H, 2'd0, L, '0, L, L, L), o_zero);
      for (int i = 0; i < 11; i++) add(beat(i), o_load);
      add(idle, o_full);
      // --- two forward replays, back-to-back; rd_start mid-replay ignored
      for (int r = 0; r < 2; r++) begin
         add(mk_i(L, 2'd0, L, '0, H, L, H), o_full);
         for (int i = 0; i < 11; i++)
            add(mk_i(L, 2'd0, L, '0, (r == 0 && i == 4), H, H), ord(i, i, (i == 10)));
      end
      add(idle_r, o_full);
      // --- AES-192 with input gap every third cycle
      add(mk_i(H, 2'd1, L, '0, L, L, L), o_full);
      b = 0;
      c = 0;
      while (b < 13) begin
         if (c % 3 == 2) add(idle, o_load);
         else begin
            add(beat('h20 + b), o_load);
            b++;
         end
         c++;
      end
      add(beat('hEE), o_full);
      add(beat('hEF), o_full);
      add(mk_i(L, 2'd0, L, '0, H, H, H), o_full);
      for (int j = 12; j >= 0; j--) add(idle_r, ord('h20 + j, j, (j == 0)));
      add(idle_r, o_full);
      // --- AES-256 reverse with out_ready toggling 1,0,1,0...
      add(mk_i(H, 2'd2, L, '0, L, L, L), o_full);
      for (int i = 0; i < 15; i++) add(beat('h80 + i), o_load);
      add(idle, o_full);
      add(mk_i(L, 2'd0, L, '0, H, H, L), o_full);
      for (int j = 0; j < 29; j++) begin
         int idx;
         idx = 14 - (j + 1) / 2;
         add(mk_i(L, 2'd0, L, '0, L, L, (j % 2 == 0)), ord('h80 + idx, idx, (idx == 0)));
      end
      add(idle, o_full);
      // --- rd_start + load_start collision (with a beat) -> LOAD, no replay
      add(mk_i(H, 2'd0, H, key('hEE), H, L, H), o_full);
      for (int i = 0; i < 11; i++) add(beat('h40 + i), o_load);
      add(idle, o_full);
      add(mk_i(L, 2'd0, L, '0, H, L, H), o_full);
      for (int i = 0; i < 5; i++) add(idle_r, ord('h40 + i, i, L));
      // abort replay at index 5
      add(mk_i(H, 2'd0, L, '0, L, L, H), ord('h45, 5, L));
      for (int i = 0; i < 3; i++) add(beat('hC0 + i), o_load);
      // restart mid-load; coincident beat dropped, in_ready low this cycle
      add(mk_i(H, 2'd0, H, key('hEE), L, L, L), o_zero);
      for (int i = 0; i < 11; i++) add(beat('hC0 + i), o_load);
      add(idle, o_full);
      add(mk_i(L, 2'd0, L, '0, H, L, H), o_full);
      for (int i = 0; i < 11; i++) add(idle_r, ord('hC0 + i, i, (i == 10)));
      add(idle_r, o_full);

      // reset state while held in reset
      @(negedge clk);
      chk(-1, got, o_zero);
      chk(-2, b_got, o_zero);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         @(posedge clk);
         #1 cur = vecs[k].i;
         @(negedge clk);
         chk(k, got, vecs[k].e);
      end

      // --- asynchronous reset in the middle of a load
      @(posedge clk);
      #1 cur = mk_i(H, 2'd0, L, '0, L, L, L);
      @(posedge clk);
      #1 cur = beat('h55);
      @(posedge clk);
      #1 chk(900, got, o_load);
      #2 rst_n = 1'b0;
      #1 chk(901, got, o_zero);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk(902, got, o_zero);
      cur = '0;

      // --- config errors on the 13-deep instance
      for (int n = 2; n < 4; n++) begin
         @(posedge clk);
         #1 b_cur = mk_i(H, 2'(n), H, '0, L, L, L);
         @(negedge clk);
         chk(910 + 3 * n, b_got, o_zero);
         @(posedge clk);
         #1 b_cur = mk_i(L, 2'd0, H, '0, L, L, L);
         @(negedge clk);
         chk(911 + 3 * n, b_got, mk_o(L, L, H, L, '0, 4'd0, L));
         @(posedge clk);
         #1;
         @(negedge clk);
         chk(912 + 3 * n, b_got, o_zero);
      end
      // AES-192 still fits and loads
      @(posedge clk);
      #1 b_cur = mk_i(H, 2'd1, L, '0, L, L, L);
      @(posedge clk);
      #1 b_cur = '0;
      @(negedge clk);
      chk(930, b_got, o_load);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/rkey_bank.md
# rkey_bank

Parametrised round-key store for the AES core. It sits between the key-expansion unit and the cipher round datapath. It accepts a stream of expanded round keys for AES-128/192/256 and holds them for reuse across blocks. On request it replays them to the round datapath over a valid/ready stream, in forward order for encryption or reverse order for decryption, tagging each key with its round index and a last flag.

## Interface
Parameters:
- KEY_W, 128, width of one round key
- MAX_RK, 15, bank depth in round keys; must be ≥ 11
- IDX_W, 4, width of round index; must satisfy 2^IDX_W ≥ MAX_RK

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_nk  in  2  key size; sampled only on load_start: 0 → 11 keys (AES-128), 1 → 13 (AES-192), 2/3 → 15 (AES-256)
- load_start  in  1  single-cycle pulse; begins a new load and discards the bank
- in_valid  in  1  round key beat valid
- in_rk  in  KEY_W  round key; round 0 first
- in_ready  out  1  bank accepts a beat this cycle
- load_done  out  1  level; bank holds a complete key set
- cfg_err  out  1  single-cycle pulse; load_start with a key count > MAX_RK
- rd_start  in  1  single-cycle pulse; begins replay
- rd_inv  in  1  sampled with rd_start: 0 → forward, 1 → reverse
- out_valid  out  1  out_rk valid
- out_rk  out  KEY_W  current round key; 0 when out_valid = 0
- out_idx  out  IDX_W  round index of out_rk; 0 when out_valid = 0
- out_last  out  1  final key of replay; qualified by out_valid
- out_ready  in  1  consumer accepts out_rk

## Operation
- States:
  - EMPTY: reset, or after a rejected load
  - LOAD: collecting keys
  - FULL: bank complete and idle
  - READ: replaying keys
- Registers:
  - nrk: key count latched from in_nk (11/13/15)
  - wr_cnt: load count, 0..nrk
  - rd_ptr: read pointer
  - inv: replay direction latched from rd_inv
- load_start, any state:
  - if nrk(in_nk) ≤ MAX_RK: latch nrk, wr_cnt ← 0, state → LOAD
  - otherwise: pulse cfg_err, state → EMPTY
  - load_start aborts an in-progress load or replay.
- LOAD:
  - in_ready = 1 except in a load_start cycle.
  - Each in_valid & in_ready writes bank[wr_cnt] ← in_rk, then wr_cnt++.
  - Acceptance of beat nrk−1 moves to FULL.
  - No other exit except load_start.
- FULL:
  - load_done = 1.
  - rd_start → READ, rd_ptr ← (rd_inv ? nrk−1 : 0), inv ← rd_inv.
  - in_valid is ignored; in_ready = 0.
- READ:
  - out_valid = 1, out_rk = bank[rd_ptr], out_idx = rd_ptr.
  - out_last = 1 when rd_ptr = (inv ? 0 : nrk−1).
  - On out_ready:
    - if out_last: state → FULL
    - else: rd_ptr ± 1
  - load_done stays 1 during READ.
  - rd_start during READ is ignored.
- rd_start in EMPTY or LOAD is ignored (no error).
- Simultaneous events:
  - load_start wins over rd_start and over an in_valid beat; that beat is not written.
- The bank is a plain register array with no reset. Only control state resets.
- Bank entries ≥ nrk are never read.

## Timing
- Reset values of outputs: in_ready 0, load_done 0, cfg_err 0, out_valid 0, out_rk 0, out_idx 0, out_last 0. State = EMPTY.
- Asserting rst_n low mid-load or mid-replay returns to EMPTY immediately. The key set is lost (load_done 0).
- Load:
  - in_ready rises the cycle after load_start.
  - load_done rises the cycle after the final beat is accepted.
  - Minimum load time is nrk cycles plus 1.
- Replay:
  - out_valid rises the cycle after rd_start.
  - With out_ready held high, one key per cycle, so nrk cycles.
  - Back-to-back replay: rd_start may be asserted in the first FULL cycle after out_last is accepted.
- Output stability: out_rk, out_idx and out_last are driven from registered state and the bank. They hold stable while out_valid & !out_ready.
- cfg_err is high for exactly the cycle after the offending load_start.
- in_ready is combinational on load_start. All other outputs are functions of registered state only.

## Test plan
- Forward AES-128: load_start with in_nk = 0, stream keys K0..K10 (Ki = i replicated), rd_start with rd_inv = 0, out_ready = 1 → out_idx 0..10 on consecutive cycles, out_rk = Ki, out_last only at idx 10, then FULL with load_done = 1.
- Reverse AES-256 with backpressure: load 15 keys, rd_start with rd_inv = 1, out_ready toggling 1,0,1,0 → out_idx 14..0, each key held stable while stalled, out_last at idx 0, 29 cycles total.
- AES-192 with gapped input: in_nk = 1, in_valid idle on every third cycle → exactly 13 writes, load_done one cycle after the 13th beat, extra in_valid afterwards ignored (in_ready = 0).
- Aborts: load_start at replay idx 5, then a new 11-key load → replay stops immediately, load_done drops, the new set is replayed correctly. rst_n low mid-load → all outputs 0 asynchronously.
- Reuse and collision: two consecutive replays from one load give identical output. rd_start + load_start in the same cycle → LOAD, no out_valid. rd_start in EMPTY → no response.
- Config error: MAX_RK = 13, load_start with in_nk = 2 → cfg_err pulse, state EMPTY, in_ready stays 0.
